// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin_to_bcd_seq_pkg;

  localparam int unsigned BCD_NIBBLE_W = 4;
  localparam int unsigned ADJ_THRESH   = 5;
  localparam int unsigned ADJ_ADD      = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Start/busy/done handshake plus data between the counter stage and the converter.
interface bin_to_bcd_seq_if
  import bin_to_bcd_seq_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
);

  logic                           start;
  logic [WIDTH-1:0]               bin;
  logic                           busy;
  logic                           done;
  logic [BCD_NIBBLE_W*DIGITS-1:0] bcd;

  modport master (
    output start,
    output bin,
    input  busy,
    input  done,
    input  bcd
  );

  modport slave (
    input  start,
    input  bin,
    output busy,
    output done,
    output bcd
  );

endinterface

// File: rtl/bin_to_bcd_seq_bcd_digit_adj.sv
// One double-dabble correction nibble: add 3 when the digit is 5 or more.
module bcd_digit_adj
  import bin_to_bcd_seq_pkg::*;
(
  input  logic [BCD_NIBBLE_W-1:0] nib_i,
  output logic [BCD_NIBBLE_W-1:0] adj_c_o
);

  always_comb begin
    adj_c_o = nib_i;
    if (nib_i >= BCD_NIBBLE_W'(ADJ_THRESH)) begin
      adj_c_o = nib_i + BCD_NIBBLE_W'(ADJ_ADD);
    end
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Iterative shift-and-add-3 converter: one shift per cycle, WIDTH cycles per result.
module bin_to_bcd_seq
  import bin_to_bcd_seq_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
)(
  input  logic             clk_50MHz,
  input  logic             reset,
  bin_to_bcd_seq_if.slave  bus
);

  localparam int unsigned BCD_W = BCD_NIBBLE_W * DIGITS;
  localparam int unsigned SR_W  = BCD_W + WIDTH;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  state_e                               state_q, state_d;
  logic [SR_W-1:0]                      sr_q, sr_d;
  logic [CNT_W-1:0]                     cnt_q, cnt_d;
  logic                                 busy_q, busy_d;
  logic                                 done_q, done_d;
  logic [BCD_W-1:0]                     bcd_q, bcd_d;

  logic [DIGITS-1:0][BCD_NIBBLE_W-1:0]  nib_adj;
  logic [SR_W-1:0]                      sr_corr;
  logic [SR_W-1:0]                      sr_shift;

  // Corrections see the pre-shift register, all digits in parallel.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .nib_i   (sr_q[WIDTH + g*BCD_NIBBLE_W +: BCD_NIBBLE_W]),
      .adj_c_o (nib_adj[g])
    );
  end

  assign sr_corr  = {nib_adj, sr_q[WIDTH-1:0]};
  assign sr_shift = SR_W'({sr_corr, 1'b0});

  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bcd_q   <= bcd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    bcd_d   = bcd_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          sr_d    = {{BCD_W{1'b0}}, bus.bin};
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sr_d  = sr_shift;
        cnt_d = cnt_q + CNT_W'(1);
        // Last shift: publish the digit field and hand back to IDLE.
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          bcd_d   = sr_shift[SR_W-1 -: BCD_W];
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.bcd  = bcd_q;

endmodule

// File: doc/bin_to_bcd_seq.md
# bin_to_bcd_seq

Sequential shift-and-add-3 (double-dabble) converter that turns the binary count from the up/down counter into packed BCD digits for the seven-segment controller. It sits between the counter stage and the display multiplexer and replaces a wide combinational converter with a small iterative datapath. A start/busy/done handshake lets the counter side request a conversion whenever the count changes. The BCD output stays stable between conversions.

## Interface
Parameters:
- WIDTH, 8: binary input width in bits.
- DIGITS, 3: number of BCD digits. Must satisfy 10^DIGITS > 2^WIDTH − 1.

Ports:
- clk_50MHz  input  1  system clock; the only clock in the block.
- reset  input  1  synchronous, active-high reset.
- start  input  1  conversion request. Sampled only in IDLE.
- bin  input  WIDTH  binary value. Captured on the accepting edge.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when bcd has been updated.
- bcd  output  4*DIGITS  packed BCD result; the most significant digit is in the top nibble.

## Operation
- States: IDLE and SHIFT.
- IDLE, start=1: load the shift register {DIGITS*4 zeros, bin}, clear the iteration counter, go to SHIFT, set busy=1.
- IDLE, start=0: hold. bcd keeps its last value.
- SHIFT, each cycle:
  - For every BCD nibble of the shift register, if the nibble is ≥ 5, add 3. Corrections are made on the pre-shift value, all nibbles in parallel.
  - Shift the corrected register left by 1.
  - Increment the iteration counter.
- SHIFT, on the iteration that performs shift number WIDTH:
  - Write the upper 4*DIGITS bits of the shifted register to bcd.
  - Pulse done=1 and clear busy.
  - Return to IDLE.
- start while busy: ignored. It is not queued, and the in-flight conversion is unaffected.
- bin changes while busy: ignored, because the value was captured at accept.
- Width rules:
  - The shift register is 4*DIGITS+WIDTH bits.
  - The iteration counter is clog2(WIDTH+1) bits.
  - A nibble can never exceed 9 after the final shift.
- Reset (at any time, including mid-SHIFT):
  - Outputs return to bcd=0, busy=0, done=0.
  - The state returns to IDLE and the shift register and counter are cleared.
  - The partial conversion is discarded.

## Timing
- Edge k samples start=1 in IDLE; busy is high from edge k to edge k+WIDTH.
- The WIDTH iterations occur on edges k+1 … k+WIDTH.
- bcd updates and done goes high on edge k+WIDTH, which is WIDTH cycles after accept (8 for the default). done is low on the following edge.
- In the done cycle the state is already IDLE, so start=1 in that cycle is accepted. This gives back-to-back conversions every WIDTH+1 cycles.
- busy and done are never high in the same cycle.
- bcd changes only on a done edge or on reset.

## Structure
- Shared package contents:
  - state enum {IDLE, SHIFT};
  - BCD_NIBBLE_W = 4;
  - ADJ_THRESH = 5;
  - ADJ_ADD = 3.
- One sub-module, bcd_digit_adj: a 4-bit combinational nibble that outputs (in ≥ 5) ? in+3 : in. It is instantiated DIGITS times via generate.
- The top level holds the FSM, iteration counter, shift register and output registers.

## Test plan
- After reset: bin=0, start pulse → busy high 8 cycles, then done with bcd=12'h000. Check done is exactly one cycle.
- bin=255, start → after 8 cycles bcd=12'h255. bin=100 → 12'h100. bin=99 → 12'h099 (covers the nibble-adjust carry boundaries).
- bin=37 start. Two cycles later, start again with bin=200 → the second start is ignored, bcd=12'h037, and exactly one done.
- Start asserted in the done cycle with a new bin=128 → second conversion accepted immediately, bcd=12'h128 after 8 more cycles. Sweep bin 0..255 back-to-back against a reference model.
- Start a conversion of 255, then assert reset at iteration 4 → next cycle busy=0, done=0, bcd=0. A fresh start with bin=42 gives 12'h042.
- Hold start high continuously with an incrementing bin → one conversion every 9 cycles, each result matching the bin captured at its accept.
